// File: rtl/boot_sequencer.sv
// Boot-image loader: copies NUM_SEG byte segments from a synchronous boot ROM
// over the dn_* download bus, then issues a single execute pulse.
module boot_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int ROM_AW  = 16,
  parameter int LEN_W   = 16,
  parameter int NUM_SEG = 2,
  parameter int ROM_LAT = 1,
  localparam int SEG_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_SEG*ROM_AW-1:0] seg_src,
  input  logic [NUM_SEG*ADDR_W-1:0] seg_dst,
  input  logic [NUM_SEG*LEN_W-1:0]  seg_len,
  input  logic [ADDR_W-1:0]         exec_addr_in,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [7:0]                rom_data,
  output logic                      dn_go,
  output logic                      dn_wr,
  output logic [ADDR_W-1:0]         dn_addr,
  output logic [7:0]                dn_data,
  input  logic                      dn_wait,
  output logic [ADDR_W-1:0]         execute_addr,
  output logic                      execute_enable,
  output logic                      busy,
  output logic                      done,
  output logic [SEG_W-1:0]          seg_index
);

  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEL   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] POST  = 3'd4;
  localparam logic [2:0] EXEC  = 3'd5;

  logic [2:0]        state;
  logic [LEN_W-1:0]  offset;
  logic [LEN_W-1:0]  next_offset;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ROM_AW-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [LEN_W-1:0]  cur_len;
  logic              last_seg;
  logic              last_byte;

  // Descriptors are read live from the flattened buses for the current segment.
  always_comb begin
    cur_src = '0;
    cur_dst = '0;
    cur_len = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (seg_index == SEG_W'(k)) begin
        cur_src = seg_src[k*ROM_AW +: ROM_AW];
        cur_dst = seg_dst[k*ADDR_W +: ADDR_W];
        cur_len = seg_len[k*LEN_W +: LEN_W];
      end
    end
  end

  assign last_seg    = (seg_index == SEG_W'(NUM_SEG - 1));
  assign last_byte   = (offset == cur_len - LEN_W'(1));
  assign next_offset = offset + LEN_W'(1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      offset         <= '0;
      wait_cnt       <= '0;
      seg_index      <= '0;
      rom_addr       <= '0;
      dn_go          <= 1'b0;
      dn_wr          <= 1'b0;
      dn_addr        <= '0;
      dn_data        <= '0;
      execute_addr   <= '0;
      execute_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      dn_wr          <= 1'b0;
      execute_enable <= 1'b0;
      // start wins in every state, restarting from segment 0 without an execute pulse
      if (start) begin
        execute_addr <= exec_addr_in;
        seg_index    <= '0;
        offset       <= '0;
        wait_cnt     <= '0;
        dn_go        <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        state        <= SEL;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SEL: begin
            if (cur_len == '0) begin
              if (last_seg) begin
                execute_enable <= 1'b1;
                dn_go          <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
                state          <= EXEC;
              end else begin
                seg_index <= seg_index + 1'b1;
              end
            end else begin
              rom_addr <= cur_src + ROM_AW'(offset);
              wait_cnt <= '0;
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (wait_cnt == WAIT_W'(ROM_LAT - 1)) begin
              dn_data <= rom_data;
              dn_addr <= cur_dst + ADDR_W'(offset);
              state   <= WRITE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          WRITE: begin
            if (!dn_wait) begin
              dn_wr <= 1'b1;
              state <= POST;
            end
          end
          POST: begin
            if (last_byte) begin
              offset <= '0;
              if (last_seg) begin
                execute_enable <= 1'b1;
                dn_go          <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
                state          <= EXEC;
              end else begin
                seg_index <= seg_index + 1'b1;
                state     <= SEL;
              end
            end else begin
              offset   <= next_offset;
              rom_addr <= cur_src + ROM_AW'(next_offset);
              wait_cnt <= '0;
              state    <= FETCH;
            end
          end
          EXEC:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized self-checking bench for boot_sequencer, scored against a
// segment-list reference model of the expected write stream and timing.
module tb_boot_sequencer;

  localparam int NSEG = 3;
  localparam int LAT  = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        dn_wait = 1'b0;
  logic [15:0] srcA [NSEG];
  logic [15:0] dstA [NSEG];
  logic [15:0] lenA [NSEG];
  logic [47:0] seg_src, seg_dst, seg_len;
  logic [15:0] exec_addr_in = '0;
  logic [15:0] rom_addr, dn_addr, execute_addr;
  logic [7:0]  rom_data, dn_data;
  logic        dn_go, dn_wr, execute_enable, busy, done;
  logic [1:0]  seg_index;

  logic [7:0]  romMem [65536];
  logic [15:0] romAddrQ = '0;

  int          cycleCnt = 0;
  int          testCnt = 0;
  int          failCnt = 0;
  int          execCnt = 0;
  int          execCycle = 0;
  int          startCycle = 0;
  logic [15:0] execAddrSeen = '0;
  logic [15:0] expExecAddr = '0;
  logic [23:0] obsQ [$];
  logic [23:0] expQ [$];
  logic        prevWait = 1'b0;
  logic        prevWr = 1'b0;

  assign seg_src = {srcA[2], srcA[1], srcA[0]};
  assign seg_dst = {dstA[2], dstA[1], dstA[0]};
  assign seg_len = {lenA[2], lenA[1], lenA[0]};

  boot_sequencer #(
    .ADDR_W(16), .ROM_AW(16), .LEN_W(16), .NUM_SEG(NSEG), .ROM_LAT(LAT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start),
    .seg_src(seg_src), .seg_dst(seg_dst), .seg_len(seg_len),
    .exec_addr_in(exec_addr_in), .rom_addr(rom_addr), .rom_data(rom_data),
    .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wait(dn_wait), .execute_addr(execute_addr),
    .execute_enable(execute_enable), .busy(busy), .done(done),
    .seg_index(seg_index)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycleCnt <= cycleCnt + 1;

  // ROM whose data is valid in the LAT-th cycle after the address changes
  always @(posedge clk_sys) romAddrQ <= rom_addr;
  assign rom_data = romMem[romAddrQ];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records writes and execute pulses, and checks the strobe rules
  always @(negedge clk_sys) begin
    if (dn_wr) begin
      checkOutput("wrAfterWait", 32'(prevWait), 32'd0);
      checkOutput("wrPulseWidth", 32'(prevWr), 32'd0);
      obsQ.push_back({dn_addr, dn_data});
    end
    if (execute_enable) begin
      execCnt++;
      execCycle = cycleCnt;
      execAddrSeen = execute_addr;
    end
    prevWait = dn_wait;
    prevWr = dn_wr;
  end

  function automatic int runCycles();
    int t = 0;
    for (int k = 0; k < NSEG; k++) t += 1 + int'(lenA[k]) * (LAT + 2);
    return t;
  endfunction

  function automatic int totalLen();
    int n = 0;
    for (int k = 0; k < NSEG; k++) n += int'(lenA[k]);
    return n;
  endfunction

  function automatic void appendRun(input int limit);
    int n = 0;
    for (int k = 0; k < NSEG; k++) begin
      for (int i = 0; i < int'(lenA[k]); i++) begin
        if (limit >= 0 && n >= limit) return;
        expQ.push_back({dstA[k] + 16'(i), romMem[srcA[k] + 16'(i)]});
        n++;
      end
    end
  endfunction

  task automatic setDesc(input int k, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    srcA[k] = s;
    dstA[k] = d;
    lenA[k] = l;
  endtask

  task automatic applyStimulus(input int restartAfter, input bit chainExec, input bit randWait);
    int  t, expExec, budget;
    bit  restarted = 1'b0;
    bit  chained = 1'b0;
    t = runCycles();
    expExec = chainExec ? 2 : 1;
    budget = 8 * (t + 20) * expExec;
    @(posedge clk_sys); #1;
    expQ.delete();
    if (restartAfter > 0) appendRun(restartAfter);
    appendRun(-1);
    if (chainExec) appendRun(-1);
    obsQ.delete();
    execCnt = 0;
    dn_wait = 1'b0;
    start = 1'b1;
    exec_addr_in = 16'($urandom);
    expExecAddr = exec_addr_in;
    for (int c = 0; c < budget && execCnt < expExec; c++) begin
      @(posedge clk_sys); #1;
      if (start) begin
        start = 1'b0;
        startCycle = cycleCnt;
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        checkOutput("doneAfterStart", 32'(done), 32'd0);
        checkOutput("dnGoAfterStart", 32'(dn_go), 32'd1);
      end else if (restartAfter > 0 && !restarted && obsQ.size() == restartAfter) begin
        start = 1'b1;
        restarted = 1'b1;
        exec_addr_in = 16'($urandom);
        expExecAddr = exec_addr_in;
      end else if (chainExec && !chained && execute_enable) begin
        start = 1'b1;
        chained = 1'b1;
        exec_addr_in = 16'($urandom);
        expExecAddr = exec_addr_in;
      end
      if (randWait) dn_wait = ($urandom_range(0, 99) < 35);
    end
    dn_wait = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    checkOutput("execCount", execCnt, expExec);
    checkOutput("writeCount", obsQ.size(), expQ.size());
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("write%0d", i), 32'(obsQ[i]), 32'(expQ[i]));
    checkOutput("execAddr", 32'(execAddrSeen), 32'(expExecAddr));
    if (!randWait) checkOutput("execLatency", execCycle - startCycle, t);
    checkOutput("doneAfterExec", 32'(done), 32'd1);
    checkOutput("busyAfterExec", 32'(busy), 32'd0);
    checkOutput("dnGoAfterExec", 32'(dn_go), 32'd0);
  endtask

  task automatic stallTest();
    setDesc(0, 16'h0200, 16'h1000, 16'd3);
    setDesc(1, 16'h0, 16'h0, 16'd0);
    setDesc(2, 16'h0, 16'h0, 16'd0);
    @(posedge clk_sys); #1;
    dn_wait = 1'b1;
    start = 1'b1;
    obsQ.delete();
    execCnt = 0;
    @(posedge clk_sys); #1;
    start = 1'b0;
    repeat (60) @(posedge clk_sys);
    #1;
    checkOutput("stallNoWrite", obsQ.size(), 0);
    checkOutput("stallBusy", 32'(busy), 32'd1);
    checkOutput("stallNoExec", execCnt, 0);
    applyStimulus(0, 1'b0, 1'b0);
  endtask

  task automatic resetTest();
    setDesc(0, 16'h0300, 16'h2000, 16'd10);
    setDesc(1, 16'h0, 16'h0, 16'd0);
    setDesc(2, 16'h0, 16'h0, 16'd0);
    @(posedge clk_sys); #1;
    start = 1'b1;
    obsQ.delete();
    execCnt = 0;
    @(posedge clk_sys); #1;
    start = 1'b0;
    for (int c = 0; c < 300 && !(dn_wr && obsQ.size() == 2); c++) begin
      @(posedge clk_sys); #1;
    end
    checkOutput("resetArm", 32'(dn_wr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("resetDnWr", 32'(dn_wr), 32'd0);
    checkOutput("resetDnGo", 32'(dn_go), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetExec", 32'(execute_enable), 32'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk_sys);
    #1;
    checkOutput("postResetWrites", obsQ.size(), 2);
    checkOutput("postResetExec", execCnt, 0);
    checkOutput("postResetBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) romMem[i] = 8'($urandom);
    for (int k = 0; k < NSEG; k++) setDesc(k, 16'h0, 16'h0, 16'd0);

    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("rstOutputs", {26'd0, dn_go, dn_wr, execute_enable, busy, done, 1'b0}, 32'd0);
    checkOutput("rstSegIndex", 32'(seg_index), 32'd0);
    checkOutput("rstRomAddr", 32'(rom_addr), 32'd0);
    checkOutput("rstDnAddr", 32'(dn_addr), 32'd0);
    checkOutput("rstExecAddr", 32'(execute_addr), 32'd0);
    reset_n = 1'b1;

    // long single segment
    setDesc(0, 16'h0000, 16'h0000, 16'd276);
    applyStimulus(0, 1'b0, 1'b0);

    // two segments, destination wraps through 0xFFFF
    setDesc(0, 16'h0010, 16'hFFFE, 16'd4);
    setDesc(1, 16'h0100, 16'h8000, 16'd2);
    setDesc(2, 16'h0000, 16'h0000, 16'd0);
    applyStimulus(0, 1'b0, 1'b0);

    // back-pressure on a short segment
    setDesc(0, 16'h0400, 16'h0040, 16'd3);
    setDesc(1, 16'h0000, 16'h0000, 16'd0);
    applyStimulus(0, 1'b0, 1'b1);

    // restart after two bytes of a ten-byte segment
    setDesc(0, 16'h0500, 16'h3000, 16'd10);
    applyStimulus(2, 1'b0, 1'b0);

    // zero-length segments around a short one
    setDesc(0, 16'h0000, 16'h0000, 16'd0);
    setDesc(1, 16'hFFFF, 16'h0700, 16'd2);
    setDesc(2, 16'h0000, 16'h0000, 16'd0);
    applyStimulus(0, 1'b0, 1'b0);

    // all segments empty
    setDesc(1, 16'h0000, 16'h0000, 16'd0);
    applyStimulus(0, 1'b0, 1'b0);

    // start landing in the execute cycle
    setDesc(0, 16'h0600, 16'h0100, 16'd2);
    setDesc(2, 16'h0610, 16'h0200, 16'd1);
    applyStimulus(0, 1'b1, 1'b0);

    stallTest();
    resetTest();

    for (int r = 0; r < 10; r++) begin
      int  restartAt;
      bit  chain, rw;
      for (int k = 0; k < NSEG; k++)
        setDesc(k, 16'($urandom), 16'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12)));
      rw = ($urandom_range(0, 2) == 0);
      restartAt = (totalLen() > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, totalLen() - 1) : 0;
      chain = (restartAt == 0 && $urandom_range(0, 4) == 0);
      applyStimulus(restartAt, chain, rw);
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Generalised boot-image loader: after a start trigger, copies NUM_SEG byte segments from a synchronous boot ROM into core memory over the dn_* download bus.
- Then pulses execute_enable once, carrying a start address.
- Sits between the top-level reset edge detector and pcw_core. It replaces the single fixed-length copy loop.
- Adds multi-segment descriptors, ROM read latency, dn_wait back-pressure and restart-on-start.

Parameters:
- ADDR_W, 16, width of dn_addr, execute_addr and segment destination addresses.
- ROM_AW, 16, boot ROM address width.
- LEN_W, 16, width of each segment length field, in bytes.
- NUM_SEG, 2, number of segment descriptors (minimum 1).
- ROM_LAT, 1, boot ROM read latency in cycles (minimum 1).

Ports:
- clk_sys  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle trigger, typically the reset negative edge.
- seg_src  in  NUM_SEG*ROM_AW  per-segment ROM source address; segment k is at [k*ROM_AW +: ROM_AW].
- seg_dst  in  NUM_SEG*ADDR_W  per-segment destination address.
- seg_len  in  NUM_SEG*LEN_W  per-segment byte count; 0 means skip the segment.
- exec_addr_in  in  ADDR_W  execution address, latched on start.
- rom_addr  out  ROM_AW  boot ROM address, registered.
- rom_data  in  8  boot ROM data, valid ROM_LAT cycles after rom_addr changes.
- dn_go  out  1  download active.
- dn_wr  out  1  one-cycle write strobe.
- dn_addr  out  ADDR_W  write address.
- dn_data  out  8  write data.
- dn_wait  in  1  sink back-pressure; while high, no new dn_wr is issued.
- execute_addr  out  ADDR_W  address accompanying execute_enable.
- execute_enable  out  1  one-cycle execute pulse.
- busy  out  1  high from the cycle after start until the execute pulse.
- done  out  1  set at the execute pulse; cleared by the next start.
- seg_index  out  clog2(NUM_SEG) or 1  current segment, for debug.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE. Every output is 0, seg_index is 0, all counters are cleared. Asserting reset mid-transfer aborts immediately with no further dn_wr or execute_enable.
- Descriptors are sampled live during transfer. They must be held stable while busy; exec_addr_in alone is latched on start.
- States: IDLE, SEL, FETCH, WRITE, POST, EXEC.
- IDLE: on start, latch exec_addr_in, set seg=0, offset=0, dn_go=1, busy=1, done=0. Go to SEL.
- SEL:
  - If seg_len[seg]==0: if seg is the last segment go to EXEC, otherwise seg++ and stay in SEL. Each skipped segment costs one cycle.
  - Otherwise: rom_addr <= seg_src[seg]+offset, then go to FETCH.
- FETCH: wait-counter runs ROM_LAT cycles. On the last cycle, capture dn_data <= rom_data and dn_addr <= seg_dst[seg]+offset, then go to WRITE.
- WRITE: sample dn_wait each cycle. When it is 0, set dn_wr <= 1 for exactly one cycle and go to POST. While it is 1, hold and keep dn_wr at 0.
- POST:
  - dn_wr returns to 0.
  - If offset == len-1: offset=0; go to EXEC if this is the last segment, otherwise seg++ and go to SEL.
  - Otherwise: offset++, rom_addr <= src+offset+1, go to FETCH.
- Throughput: ROM_LAT+2 cycles per byte when dn_wait=0, plus one SEL cycle per segment.
- EXEC:
  - execute_enable=1 for one cycle, with execute_addr = latched exec address.
  - In the same cycle, dn_go=0 and busy=0; done=1 from this cycle on.
  - Then return to IDLE.
  - execute_addr holds its value until the next start.
- Arithmetic: source and destination address adds wrap modulo 2^ROM_AW and 2^ADDR_W. offset is LEN_W bits wide; the maximum length is 2^LEN_W-1.
- start while busy (any state other than IDLE): the run restarts.
  - The next state is SEL with seg=0 and offset=0, and exec_addr_in is re-latched.
  - A pending write in WRITE is discarded. A dn_wr already high completes its single cycle.
  - No execute pulse is issued for the aborted run; dn_go stays 1.
- start in the EXEC cycle: execute_enable still pulses, then the new run begins. done clears on the following cycle.
- All segments of length 0: start leads to NUM_SEG SEL cycles, then EXEC. No dn_wr is issued.
- dn_wait held high indefinitely: the block stalls in WRITE. Only start or reset recovers it.

Test Plan:
- Case 1 (basic copy):
  - Setup: NUM_SEG=1, ROM_LAT=1, src=0x0000, dst=0x0000, len=276, ROM byte i = i[7:0]; pulse start.
  - Required: 276 dn_wr pulses with addr 0..275 and data matching the ROM; dn_go high throughout.
  - Required: execute_enable pulses once, 276*3+1 cycles after SEL entry, with execute_addr = exec_addr_in; done=1.
- Case 2 (two segments, wrap):
  - Setup: seg0 src=0x0010, dst=0xFFFE, len=4; seg1 src=0x0100, dst=0x8000, len=2.
  - Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x8000, 0x8001 with ROM data from 0x10..0x13 and 0x100..0x101, then one execute pulse.
- Case 3 (back-pressure):
  - Setup: len=3; raise dn_wait for 5 cycles while in WRITE on byte 1.
  - Required: no dn_wr during the wait; exactly 3 dn_wr pulses total; data and address order unchanged.
- Case 4 (restart):
  - Setup: pulse start again after 2 bytes of a 10-byte segment.
  - Required: the address sequence restarts at dst+0; 12 dn_wr pulses total; exactly one execute_enable.
- Case 5 (zero lengths, latency):
  - Setup: NUM_SEG=3 with lengths 0, 2, 0 and ROM_LAT=3.
  - Required: 2 writes spaced 5 cycles apart; execute pulses after the final SEL skip.
- Case 6 (reset mid-transfer):
  - Setup: drive reset_n low asynchronously mid-transfer.
  - Required: dn_go, dn_wr, busy and execute_enable go to 0 immediately; nothing is written after release until the next start.
